// File: rtl/pipeline_ctrl_pkg.sv
// Shared control-word layout and fixed encodings for the pipeline
// control-word register chain.
package pipeline_ctrl_pkg;

    localparam int INSTR_W    = 16;
    localparam int CC_WIDTH   = 16;

    // Control-word field positions, shared with the hazard unit
    localparam int RF_WE      = 15;
    localparam int RF_ADDR_HI = 14;
    localparam int RF_ADDR_LO = 12;
    localparam int OPCODE_HI  = 11;
    localparam int OPCODE_LO  = 8;

    localparam logic [3:0] OPCODE_NOP = 4'h0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    // A bubble never writes the register file and carries the NOP opcode,
    // so it can never match in a hazard comparison.
    function automatic logic [CC_WIDTH-1:0] make_bubble();
        logic [CC_WIDTH-1:0] cw;
        cw                      = {CC_WIDTH{1'b0}};
        cw[RF_WE]               = 1'b0;
        cw[OPCODE_HI:OPCODE_LO] = OPCODE_NOP;
        return cw;
    endfunction

    localparam logic [CC_WIDTH-1:0] CC_BUBBLE = make_bubble();

endpackage

// File: rtl/pipeline_ctrl_stage_reg.sv
// Single pipeline stage register: holds when not enabled, otherwise loads
// either the incoming word or the supplied bubble value.
module stage_reg #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load_bubble,
    input  logic [W-1:0] d,
    input  logic [W-1:0] bubble,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Stage storage with asynchronous reset to the bubble/NOP encoding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else if (en) begin
            q_r <= load_bubble ? bubble : d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control-word register chain: Stage1 instruction plus the
// Stage2..Stage4 control words, with stall/flush handling and saturating
// performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                En,
    input  logic [INSTR_W-1:0]  Instr_in,
    input  logic                Instr_valid,
    input  logic [CC_WIDTH-1:0] Dec_cw,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                Cnt_clr,
    output logic [INSTR_W-1:0]  Stage1,
    output logic [CC_WIDTH-1:0] Stage2,
    output logic [CC_WIDTH-1:0] Stage3,
    output logic [CC_WIDTH-1:0] Stage4,
    output logic [3:0]          V,
    output logic                Pc_en,
    output logic [CNT_W-1:0]    Stall_cnt,
    output logic [CNT_W-1:0]    Flush_cnt
);

    logic             flush_s;
    logic             stall_s;
    logic             s1_en_s;
    logic             s1_bubble_s;
    logic             s2_bubble_s;
    logic [3:0]       v_next_s;
    logic [3:0]       v_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating increment: sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end else begin
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Event decode and valid-bit next state; Flush outranks Stall
    always_comb begin
        flush_s     = En & Flush;
        stall_s     = En & Stall & ~Flush;
        s1_en_s     = En & ~(Stall & ~Flush);
        s1_bubble_s = Flush | ~Instr_valid;
        s2_bubble_s = Flush | Stall | ~v_r[0];
        v_next_s    = v_r;
        if (Flush) begin
            v_next_s = {v_r[2], v_r[1], 1'b0, 1'b0};
        end else if (Stall) begin
            v_next_s = {v_r[2], v_r[1], 1'b0, v_r[0]};
        end else begin
            v_next_s = {v_r[2], v_r[1], v_r[0], Instr_valid};
        end
    end

    stage_reg #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_stage1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (s1_en_s),
        .load_bubble (s1_bubble_s),
        .d           (Instr_in),
        .bubble      (NOP_INSTR),
        .q           (Stage1)
    );

    stage_reg #(.W(CC_WIDTH), .RST_VAL(CC_BUBBLE)) u_stage2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (En),
        .load_bubble (s2_bubble_s),
        .d           (Dec_cw),
        .bubble      (CC_BUBBLE),
        .q           (Stage2)
    );

    stage_reg #(.W(CC_WIDTH), .RST_VAL(CC_BUBBLE)) u_stage3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (En),
        .load_bubble (1'b0),
        .d           (Stage2),
        .bubble      (CC_BUBBLE),
        .q           (Stage3)
    );

    stage_reg #(.W(CC_WIDTH), .RST_VAL(CC_BUBBLE)) u_stage4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (En),
        .load_bubble (1'b0),
        .d           (Stage3),
        .bubble      (CC_BUBBLE),
        .q           (Stage4)
    );

    // Stage valid bits, frozen when the pipeline is halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= 4'b0000;
        end else if (En) begin
            v_r <= v_next_s;
        end else begin
            v_r <= v_r;
        end
    end

    // Stall event counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (En && Cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Flush event counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (En && Cnt_clr) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_s) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Fetch may advance unless halted, in reset, or stalled without a flush
    assign Pc_en     = En & rst_n & (Flush | ~Stall);
    assign V         = v_r;
    assign Stall_cnt = stall_cnt_r;
    assign Flush_cnt = flush_cnt_r;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control-word register chain for the 4-stage core. Produces the Stage1 instruction word and the Stage2/Stage3/Stage4 control words that the hazard unit reads. Applies the hazard unit's Stall and the execute stage's branch Flush by freezing fetch, holding decode and injecting bubbles. Also keeps saturating stall and flush event counters for performance debug.

## Interface
- CNT_W, default 16: width of each performance counter.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- En  in  1  global advance enable (single-step/halt); 0 freezes every register, counters included.
- Instr_in  in  16  fetched instruction.
- Instr_valid  in  1  Instr_in is valid this cycle.
- Dec_cw  in  `CC_WIDTH  decoder control word for the instruction currently in Stage1 (combinational from Stage1).
- Stall  in  1  from hazard unit: load/input use hazard on Stage1.
- Flush  in  1  branch/jump taken, resolved in execute stage.
- Cnt_clr  in  1  synchronous clear of both counters.
- Stage1  out  16  decode-stage instruction.
- Stage2, Stage3, Stage4  out  `CC_WIDTH each  execute, memory-access and write-back control words.
- V  out  4  stage valid bits; V[0] is Stage1 and V[3] is Stage4.
- Pc_en  out  1  PC/fetch advance enable.
- Stall_cnt, Flush_cnt  out  CNT_W each  event counters.

## Operation
- Priority per enabled cycle (En=1): Flush > Stall > normal.
- Normal:
  - Stage1 <= Instr_valid ? Instr_in : `NOP_INSTR.
  - V[0] <= Instr_valid.
  - Stage2 <= Dec_cw and V[1] <= V[0].
  - Stage3 <= Stage2 and Stage4 <= Stage3, valid bits shift with them.
- Stall (Flush=0):
  - Stage1 and V[0] hold.
  - Stage2 <= `CC_BUBBLE and V[1] <= 0.
  - Stage3 and Stage4 shift as normal.
  - Stall_cnt increments.
- Flush:
  - Stage1 <= `NOP_INSTR with V[0] <= 0.
  - Stage2 <= `CC_BUBBLE with V[1] <= 0.
  - Stage3 and Stage4 shift, so the branch itself completes.
  - Flush_cnt increments.
  - A simultaneous Stall is ignored and Stall_cnt does not count it.
- A bubble has RF_WE=0 and OPCODE=NOP, so it never matches in hazard comparisons.
- Stage2 always loads a bubble when V[0]=0, whatever Dec_cw is.
- Counters saturate at all-ones. Cnt_clr takes priority over an increment in the same cycle. Cnt_clr acts only when En=1.
- En=0: all outputs hold, Pc_en=0, Stall and Flush are ignored.

## Timing
- Reset (asynchronous, immediate):
  - Stage1 = `NOP_INSTR.
  - Stage2, Stage3 and Stage4 = `CC_BUBBLE.
  - V = 4'b0000 and both counters = 0.
  - Pc_en = 0 while rst_n=0.
- Pc_en is combinational: En & rst_n & (Flush | ~Stall).
- All stage outputs are registered, with 1-cycle latency per stage. An instruction accepted at edge n is in Stage4 at edge n+3 unless it is stalled.
- Each stall cycle adds exactly 1 cycle to the Stage1 instruction's latency and inserts 1 bubble into Stage2.
- rst_n deasserted mid-operation: first capture on the first rising edge with rst_n=1.
- Reset asserted mid-stall: the stall is discarded and the pipeline restarts empty.

## Structure
- Additions to defines.v, beside the existing field macros:
  - `CC_BUBBLE
  - `NOP_INSTR
  - the NOP opcode
  - `RF_WE, `RF_ADDR and `OPCODE, reused unchanged.
- One sub-module, stage_reg: parameter W; inputs en, load_bubble, d and bubble value; holds on ~en. Instantiated once for Stage1 (16 bits) and three times for the control words, plus valid-bit flops.
- Counters and priority logic live in pipeline_ctrl.

## Test plan
- Straight-line: four valid instructions A–D on consecutive cycles.
  - Dec_cw(A) appears in Stage2 at edge 2, Stage3 at edge 3 and Stage4 at edge 4.
  - V reaches 4'b1111 after edge 4.
- Single stall: Stall=1 for one cycle with X in Stage1.
  - Stage1 holds X and Pc_en=0 that cycle.
  - Stage2 = `CC_BUBBLE and V[1]=0.
  - Next cycle Stage2 = Dec_cw(X) and Stall_cnt = 1.
- Flush and Stall together for one cycle:
  - Stage1 = `NOP_INSTR and Stage2 = `CC_BUBBLE, V[1:0] = 0.
  - Pc_en = 1, Flush_cnt = 1, Stall_cnt = 0.
  - Stage3 receives the old Stage2.
- En=0 for 3 cycles with Stall=1 and Flush toggling: all outputs and counters unchanged, Pc_en = 0.
- Counter saturation with CNT_W=4:
  - 20 stall cycles give Stall_cnt = 15.
  - Cnt_clr together with Stall gives Stall_cnt = 0.
- Asynchronous reset asserted mid-stream, between clock edges: outputs go to reset values immediately; after release the first valid instruction reaches Stage4 3 cycles after it enters Stage1.
